booth_seq_ctrl: RTL and testbench

Sequential controller for radix-2 Booth signed multiplication. It accepts one operand pair through a valid/ready handshake and evaluates one Booth digit per clock into an internal accumulator. It then holds the signed product on an output valid/ready handshake. The block sits between an operand producer and a product consumer, in designs where a combinational Booth array is too large or too slow.

---
 rtl/booth_seq_ctrl_if.sv | 23 ++
 rtl/booth_seq_ctrl.sv | 99 +++++++++
 tb/tb_booth_seq_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_seq_ctrl_if.sv
// Operand-in / product-out handshake bundle for booth_seq_ctrl.
// The multiplier is the slave: it consumes operands and produces the product.
interface booth_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth signed multiplier.
// Evaluates one Booth digit per clock into ACC, then holds the product on a valid/ready output.
module booth_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  booth_seq_ctrl_if.slave            bus,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] step
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic [1:0]       digit;
  logic [PW-1:0]    m_shift;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;

    // Appending the implicit Q[-1]=0 lets the digit be read with a plain shift.
    digit   = 2'({q_q, 1'b0} >> step_q);
    m_shift = m_q << step_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          m_d     = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
          q_d     = bus.b;
          acc_d   = '0;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        case (digit)
          2'b01:   acc_d = acc_q + m_shift;
          2'b10:   acc_d = acc_q - m_shift;
          default: acc_d = acc_q;
        endcase
        step_d = step_q + SW'(1);
        if (step_q == LAST_STEP) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          step_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        step_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.product   = acc_q;
  assign busy          = (state_q != S_IDLE);
  assign step          = step_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl: directed WIDTH=4 vectors, full 4-bit sweep, random WIDTH=8 subset.
module tb_booth_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_seq_ctrl_if #(.WIDTH(4)) bus4 ();
  booth_seq_ctrl_if #(.WIDTH(8)) bus8 ();

  logic       busy4, busy8;
  logic [2:0] step4;
  logic [3:0] step8;

  booth_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4),
    .busy  (busy4),
    .step  (step4)
  );

  booth_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8),
    .busy  (busy8),
    .step  (step8)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp4_q[$];
  logic [15:0] exp8_q[$];

  logic rnd_mode = 1'b0;
  logic ordy_val = 1'b1;
  logic rnd4 = 1'b0;
  logic rnd8 = 1'b0;

  always_comb bus4.out_ready = rnd_mode ? rnd4 : ordy_val;
  always_comb bus8.out_ready = rnd_mode ? rnd8 : ordy_val;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd4 = 1'($urandom_range(0, 1));
      rnd8 = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Monitors: a product transfers on the edge following a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (exp4_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb4_unexpected actual=%h required=none", bus4.product);
      end else begin
        check("sb4_product", 16'(bus4.product), 16'(exp4_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb8_unexpected actual=%h required=none", bus8.product);
      end else begin
        check("sb8_product", bus8.product, exp8_q.pop_front());
      end
    end
  end

  task automatic wait_idle4();
    int n = 0;
    while (!bus4.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) timeout_fail("wait_idle4");
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (!bus8.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) timeout_fail("wait_idle8");
  endtask

  // Exact-latency transaction at WIDTH=4 with out_ready held high.
  task automatic op_timed(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] req,
                          input string tag);
    wait_idle4();
    bus4.a = av;
    bus4.b = bv;
    bus4.in_valid = 1'b1;
    exp4_q.push_back(req);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    check({tag, "_in_ready_low"}, 16'(bus4.in_ready), 16'd0);
    check({tag, "_step0"}, 16'(step4), 16'd0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_no_valid_early"}, 16'(bus4.out_valid), 16'd0);
      check({tag, "_step_run"}, 16'(step4), 16'(k));
    end
    @(posedge clk);
    #1;
    check({tag, "_out_valid"}, 16'(bus4.out_valid), 16'd1);
    check({tag, "_product"}, 16'(bus4.product), 16'(req));
    check({tag, "_step_done"}, 16'(step4), 16'd4);
    @(posedge clk);
    #1;
    check({tag, "_valid_one_cycle"}, 16'(bus4.out_valid), 16'd0);
    check({tag, "_in_ready_back"}, 16'(bus4.in_ready), 16'd1);
    check({tag, "_product_held_idle"}, 16'(bus4.product), 16'(req));
  endtask

  task automatic send4(input logic [3:0] av, input logic [3:0] bv, input int gap);
    int pa;
    int pb;
    int p;
    pa = int'($signed(av));
    pb = int'($signed(bv));
    p  = pa * pb;
    wait_idle4();
    bus4.a = av;
    bus4.b = bv;
    bus4.in_valid = 1'b1;
    exp4_q.push_back(p[7:0]);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input int gap);
    int pa;
    int pb;
    int p;
    pa = int'($signed(av));
    pb = int'($signed(bv));
    p  = pa * pb;
    wait_idle8();
    bus8.a = av;
    bus8.b = bv;
    bus8.in_valid = 1'b1;
    exp8_q.push_back(p[15:0]);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp4_q.size() != 0 || exp8_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) timeout_fail("drain");
  endtask

  initial begin
    bus4.in_valid = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus8.in_valid = 1'b0;
    bus8.a = '0;
    bus8.b = '0;

    #3;
    check("rst_in_ready", 16'(bus4.in_ready), 16'd1);
    check("rst_out_valid", 16'(bus4.out_valid), 16'd0);
    check("rst_busy", 16'(busy4), 16'd0);
    check("rst_step", 16'(step4), 16'd0);
    check("rst_product", 16'(bus4.product), 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op_timed(4'd3, 4'hE, 8'hFA, "basic");
    op_timed(4'h8, 4'h8, 8'h40, "neg8_neg8");
    op_timed(4'h8, 4'h7, 8'hC8, "neg8_7");
    op_timed(4'h7, 4'h7, 8'h31, "7_7");
    op_timed(4'h0, 4'hF, 8'h00, "0_neg1");

    // Back-pressure: DONE held for 6 cycles while a new pair is offered.
    wait_idle4();
    ordy_val = 1'b0;
    bus4.a = 4'd5;
    bus4.b = 4'hD;
    bus4.in_valid = 1'b1;
    exp4_q.push_back(8'hF1);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus4.a = 4'd1;
    bus4.b = 4'd1;
    bus4.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("bp_out_valid", 16'(bus4.out_valid), 16'd1);
      check("bp_product", 16'(bus4.product), 16'hF1);
      check("bp_in_ready", 16'(bus4.in_ready), 16'd0);
      @(posedge clk);
      #1;
    end
    bus4.in_valid = 1'b0;
    ordy_val = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 16'(bus4.in_ready), 16'd1);
    check("bp_release_busy", 16'(busy4), 16'd0);
    @(posedge clk);
    #1;
    check("bp_not_queued", 16'(busy4), 16'd0);

    // Operands changed during RUN must not affect the result.
    wait_idle4();
    bus4.a = 4'd2;
    bus4.b = 4'd3;
    bus4.in_valid = 1'b1;
    exp4_q.push_back(8'h06);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    bus4.a = 4'hF;
    bus4.b = 4'hF;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    check("opchg_out_valid", 16'(bus4.out_valid), 16'd1);
    check("opchg_product", 16'(bus4.product), 16'h06);
    @(posedge clk);
    #1;

    // Reset asserted mid-RUN at step 2.
    wait_idle4();
    bus4.a = 4'd3;
    bus4.b = 4'd3;
    bus4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_step2", 16'(step4), 16'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 16'(bus4.in_ready), 16'd1);
    check("mid_rst_out_valid", 16'(bus4.out_valid), 16'd0);
    check("mid_rst_busy", 16'(busy4), 16'd0);
    check("mid_rst_step", 16'(step4), 16'd0);
    check("mid_rst_product", 16'(bus4.product), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_pulse", 16'(bus4.out_valid), 16'd0);
    op_timed(4'hC, 4'h4, 8'hF0, "after_rst");

    // Exhaustive 4-bit sweep with random gaps and back-pressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send4(4'(i >> 4), 4'(i), $urandom_range(0, 2));
    end
    send8(8'h80, 8'h80, 0);
    send8(8'h80, 8'h7F, 1);
    for (int i = 0; i < 48; i++) begin
      send8(8'($urandom), 8'($urandom), $urandom_range(0, 2));
    end
    drain();
    rnd_mode = 1'b0;
    ordy_val = 1'b1;
    @(posedge clk);
    #1;
    check("final_idle4", 16'(busy4), 16'd0);
    check("final_idle8", 16'(busy8), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
